// File: rtl/measure_rx_check_if.sv
// XGMII receive bundle: 64-bit data with one control bit per byte lane.
// The generator/loopback side drives it (master); the checker samples it (slave).
interface measure_rx_check_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/measure_rx_check.sv
// XGMII RX checker for measurement test frames: FCS check, one-way latency, per-second stats.
// CRC engines are MSB-first CRC-32 (0x04C11DB7) fed with bit-reversed lanes, lane 0 first.
module crc32_d64 (
  input  logic [31:0] i_crc,
  input  logic [63:0] i_data,
  output logic [31:0] o_crc
);
  always_comb begin
    o_crc = i_crc;
    for (int i = 63; i >= 0; i--) begin
      if (o_crc[31] ^ i_data[i]) o_crc = {o_crc[30:0], 1'b0} ^ 32'h04C11DB7;
      else                       o_crc = {o_crc[30:0], 1'b0};
    end
  end
endmodule

module crc32_d32 (
  input  logic [31:0] i_crc,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);
  always_comb begin
    o_crc = i_crc;
    for (int i = 31; i >= 0; i--) begin
      if (o_crc[31] ^ i_data[i]) o_crc = {o_crc[30:0], 1'b0} ^ 32'h04C11DB7;
      else                       o_crc = {o_crc[30:0], 1'b0};
    end
  end
endmodule

module measure_rx_check #(
  parameter logic [31:0] MAGIC_CODE  = 32'hA5A5_5A5A,
  parameter logic [15:0] MAX_WORDS   = 16'd190,
  parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sec_oneshot,
  input  logic [31:0]       global_counter,
  measure_rx_check_if.slave xgmii,
  output logic [31:0]       rx_pps,
  output logic [31:0]       rx_throughput,
  output logic [23:0]       rx_latency,
  output logic [31:0]       rx_ipv4_ip,
  output logic [31:0]       rx_crc_err,
  output logic              rx_frame_ok
);
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_CHECK} state_t;
  state_t r_state, w_state_next;

  logic [7:0]  w_lane [8];
  logic [63:0] w_rev64;
  logic [7:0]  w_err_lane;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign w_lane[gi]     = xgmii.xgmii_rxd[8*gi +: 8];
      assign w_err_lane[gi] = xgmii.xgmii_rxc[gi] && (w_lane[gi] == 8'hfe);
      for (gj = 0; gj < 8; gj++) begin : g_bit
        assign w_rev64[8*(7-gi)+gj] = w_lane[gi][7-gj];
      end
    end
  endgenerate

  logic w_start, w_data, w_term0, w_term4, w_err_char;
  assign w_start    = (xgmii.xgmii_rxc == 8'h01) && (xgmii.xgmii_rxd == 64'hd5555555555555fb);
  assign w_data     = (xgmii.xgmii_rxc == 8'h00);
  assign w_term0    = (xgmii.xgmii_rxc == 8'hff) && (w_lane[0] == 8'hfd);
  assign w_term4    = (xgmii.xgmii_rxc == 8'hf0) && (w_lane[4] == 8'hfd);
  assign w_err_char = |w_err_lane;

  logic [31:0] r_crc, r_res, w_crc64, w_crc32;
  crc32_d64 u_crc64 (.i_crc(r_crc), .i_data(w_rev64),        .o_crc(w_crc64));
  crc32_d32 u_crc32 (.i_crc(r_crc), .i_data(w_rev64[63:32]), .o_crc(w_crc32));

  logic [15:0] r_word, r_len, w_len_now;
  logic        r_not_test;
  logic [31:0] r_dstip, r_stamp, r_rx_time, r_acc_pps, r_acc_bytes;
  logic [31:0] r_pps, r_thru, r_ipv4, r_crc_err, w_diff;
  logic [23:0] r_latency, w_latency;
  logic        r_frame_ok;
  logic        w_crc_init, w_crc_en, w_term, w_err_inc, w_good;

  // r_word is the index of the word about to arrive, so it is one past the data-word count here.
  assign w_len_now = {r_word[12:0] - 13'd1, 3'b000} + (w_term4 ? 16'd4 : 16'd0);
  assign w_diff    = r_rx_time - r_stamp;
  assign w_latency = (w_diff[31:24] == 8'd0) ? w_diff[23:0] : 24'hffffff;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_crc_init   = 1'b0;
    w_crc_en     = 1'b0;
    w_term       = 1'b0;
    w_err_inc    = 1'b0;
    w_good       = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_start) begin
        w_crc_init   = 1'b1;
        w_state_next = S_HDR;
      end
      S_HDR, S_BODY: begin
        if (w_start) begin
          w_err_inc    = 1'b1;
          w_crc_init   = 1'b1;
          w_state_next = S_HDR;
        end else if (w_err_char) begin
          w_err_inc    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_data) begin
          if (r_word > MAX_WORDS) begin
            w_err_inc    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_crc_en     = 1'b1;
            w_state_next = (r_word >= 16'd7) ? S_BODY : S_HDR;
          end
        end else if (w_term0 || w_term4) begin
          w_term       = 1'b1;
          w_state_next = S_CHECK;
        end else begin
          w_err_inc    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_CHECK: begin
        w_good    = (r_res == CRC_RESIDUE) && !r_not_test && (r_len >= 16'd64);
        w_err_inc = (r_res != CRC_RESIDUE);
        if (w_start) begin
          w_crc_init   = 1'b1;
          w_state_next = S_HDR;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_crc       <= '0;
      r_res       <= '0;
      r_word      <= '0;
      r_len       <= '0;
      r_not_test  <= 1'b0;
      r_dstip     <= '0;
      r_stamp     <= '0;
      r_rx_time   <= '0;
      r_acc_pps   <= '0;
      r_acc_bytes <= '0;
      r_pps       <= '0;
      r_thru      <= '0;
      r_ipv4      <= '0;
      r_crc_err   <= '0;
      r_latency   <= '0;
      r_frame_ok  <= 1'b0;
    end else begin
      if (w_crc_init) begin
        r_crc      <= 32'hffffffff;
        r_word     <= 16'd1;
        r_not_test <= 1'b0;
      end else if (w_crc_en) begin
        r_crc  <= w_crc64;
        r_word <= r_word + 16'd1;
        // Header fields are network byte order, lane 0 carrying the most significant byte.
        case (r_word)
          16'd2: if ({w_lane[4], w_lane[5]} != 16'h0800) r_not_test <= 1'b1;
          16'd3: if (w_lane[7] != 8'h11) r_not_test <= 1'b1;
          16'd4: r_dstip[31:16] <= {w_lane[6], w_lane[7]};
          16'd5: r_dstip[15:0]  <= {w_lane[0], w_lane[1]};
          16'd6: begin
            if ({w_lane[2], w_lane[3], w_lane[4], w_lane[5]} != MAGIC_CODE) r_not_test <= 1'b1;
            r_stamp[31:16] <= {w_lane[6], w_lane[7]};
            r_rx_time      <= global_counter;
          end
          16'd7: r_stamp[15:0] <= {w_lane[0], w_lane[1]};
          default: ;
        endcase
      end
      if (w_term) begin
        r_res <= w_term4 ? w_crc32 : r_crc;
        r_len <= w_len_now;
      end
      r_frame_ok <= w_good;
      if (w_good) begin
        r_latency <= w_latency;
        r_ipv4    <= r_dstip;
      end
      if (w_err_inc) r_crc_err <= r_crc_err + 32'd1;
      // A frame finishing on the second boundary opens the new window.
      if (sec_oneshot) begin
        r_pps       <= r_acc_pps;
        r_thru      <= r_acc_bytes;
        r_acc_pps   <= w_good ? 32'd1 : 32'd0;
        r_acc_bytes <= w_good ? {16'h0, r_len} : 32'd0;
      end else if (w_good) begin
        r_acc_pps   <= r_acc_pps + 32'd1;
        r_acc_bytes <= r_acc_bytes + {16'h0, r_len};
      end
    end
  end

  assign rx_pps        = r_pps;
  assign rx_throughput = r_thru;
  assign rx_latency    = r_latency;
  assign rx_ipv4_ip    = r_ipv4;
  assign rx_crc_err    = r_crc_err;
  assign rx_frame_ok   = r_frame_ok;
endmodule
